vga_sync_generator: RTL and testbench
=====================================

# vga_sync_generator

Pixel-timing and sync generator for the VGA output path. It derives the pixel clock from the board clock and runs the horizontal and vertical counters. It publishes counter values and active-window constants to the upstream pixel source (ROM address generator), then registers the incoming 4:4:4 colour and blanks it outside the visible window. It drives HSYNC, VSYNC and the 12-bit DAC pins directly. Default timing is 800x600@72 Hz from a 100 MHz clock.

## Interface
Parameters:
- CLK_DIV, 2: board clocks per pixel; even, ≥2.
- H_SYNC, 120: hsync width in pixels.
- H_BP, 64: horizontal back porch in pixels.
- H_ACTIVE, 800: visible pixels per line.
- H_FP, 56: horizontal front porch in pixels.
- V_SYNC, 6: vsync width in lines.
- V_BP, 23: vertical back porch in lines.
- V_ACTIVE, 600: visible lines per frame.
- V_FP, 37: vertical front porch in lines.
- SYNC_POL, 1: asserted sync level (1 = positive).

Ports:
- clock  in  1  board clock, 100 MHz.
- reset_n  in  1  reset: asynchronous, active-low.
- red_in, green_in, blue_in  in  4 each  colour from the pixel source.
- pixel_clock  out  1  divided clock, 50% duty, period CLK_DIV clocks.
- pixel_count  out  11  horizontal counter, 0..H_TOTAL-1.
- line_count  out  11  vertical counter, 0..V_TOTAL-1.
- h_active_start  out  11  constant H_SYNC+H_BP (184).
- h_active  out  11  constant H_ACTIVE.
- v_active_start  out  11  constant V_SYNC+V_BP (29).
- v_active  out  11  constant V_ACTIVE.
- frame_start  out  1  one-pixel-period pulse while counters = (0,0).
- hsync, vsync  out  1 each  sync outputs.
- red_out, green_out, blue_out  out  4 each  DAC outputs.

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (1040). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (666).
- Segment order within each axis: sync, back porch, active, front porch. Counter 0 is the first sync pixel/line.
- Divider:
  - mod-CLK_DIV counter in the clock domain.
  - pixel_clock low for the first CLK_DIV/2 clocks, high for the remainder.
  - pixel tick = the clock edge on which pixel_clock goes 0→1.
- On each pixel tick:
  - pixel_count increments and wraps H_TOTAL-1→0.
  - line_count increments only on that wrap, and wraps V_TOTAL-1→0 on the same tick.
- video_on = pixel_count in [h_active_start, h_active_start+H_ACTIVE) AND line_count in [v_active_start, v_active_start+V_ACTIVE). Evaluated on pre-tick counter values.
- On each pixel tick, from pre-tick counter values:
  - colour out <= video_on ? colour in : 0.
  - hsync <= (pixel_count < H_SYNC) ? SYNC_POL : !SYNC_POL.
  - vsync likewise from line_count < V_SYNC.
- The pixel source updates colour on the pixel_clock falling edge. Colour is therefore stable half a pixel before the sampling tick.
- frame_start is combinational from the counters.
- Constant outputs are parameter-derived and independent of reset.
- Reset values:
  - divider 0, pixel_clock 0, counters 0;
  - hsync/vsync = !SYNC_POL;
  - colour out 0.
  - frame_start is therefore 1 during reset.
- Reset asserted mid-frame clears everything immediately. After release, the first pixel tick occurs CLK_DIV/2 clocks later and the frame restarts at (0,0).

## Timing
- Pixel period = CLK_DIV clocks (20 ns default).
- Latency: colour, hsync and vsync each lag the counter value that produced them by exactly one pixel period. Syncs and colour stay mutually aligned.
- Line = 1040 pixel periods. Frame = 666 lines = 692,640 pixel periods.
- hsync asserted for 120 consecutive pixel periods per line. vsync asserted for 6 full lines.
- Simultaneous end-of-line and end-of-frame: both counters return to 0 on the same tick.
- No back-pressure. The source must present valid colour every pixel.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants for 800x600@72;
  - derived H_TOTAL/V_TOTAL;
  - counter width constant (11).
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters: sync, back porch, active, front porch;
  - inputs: enable;
  - outputs: count, wrap, sync_raw, active_raw.
- Divider, frame_start decode and output registers live in the top.

## Test plan
- Reset: hold reset_n=0 → counters 0, pixel_clock 0, hsync=vsync=0, RGB 0, frame_start 1. Release → first pixel tick after 1 clock (CLK_DIV=2).
- Divider: free run → pixel_clock period 20 ns, 50% duty. pixel_count steps once per period, 0..1039 then 0.
- Horizontal sync: hsync high for exactly 120 pixel periods, starting one period after pixel_count=0, repeating every 1040 periods.
- Vertical sync and wrap: vsync high for 6×1040 pixel periods. At (1039,665) the next tick gives (0,0), frame_start=1, frame length 692,640 periods.
- Blanking: red_in=F held constant, line_count=100.
  - Counter 183 → red_out=0 one period later.
  - Counter 184 → red_out=F one period later.
  - Counter 984 → red_out=0 one period later.
  - Line 28 or line 629 → red_out=0 everywhere.
- Mid-frame reset at (500,300) → immediate return to reset values. Sequence restarts from (0,0) with the correct sync timing.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA sync generator.
// Defaults describe 800x600@72 Hz from a 100 MHz board clock.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_SYNC_POL = 1;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

  // Maps a logical "sync asserted" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input int pol);
    if (pol != 0) begin
      return asserted;
    end else begin
      return ~asserted;
    end
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: free-running position counter ordered sync, back porch,
// active, front porch, with combinational segment decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_raw,
  output logic             active_raw
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BP + ACTIVE);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             wrap_s;

  assign wrap_s = (count_r == LAST);

  // Next position: advance on enable, returning to zero after the last position.
  always_comb begin
    count_next_s = count_r;
    if (enable) begin
      if (wrap_s) begin
        count_next_s = CNT_W'(0);
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Position register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= CNT_W'(0);
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count      = count_r;
  assign wrap       = wrap_s;
  assign sync_raw   = (count_r < SYNC_END);
  assign active_raw = (count_r >= ACT_START) && (count_r < ACT_END);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA pixel-clock divider, horizontal/vertical timing and registered
// sync/colour outputs that lag the producing counter value by one pixel.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       red_in,
  input  logic [3:0]       green_in,
  input  logic [3:0]       blue_in,
  output logic             pixel_clock,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] h_active_start,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active_start,
  output logic [CNT_W-1:0] v_active,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       red_out,
  output logic [3:0]       green_out,
  output logic [3:0]       blue_out
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic SYNC_OFF = sync_level(1'b0, SYNC_POL);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             pixel_clock_r;
  logic             tick_s;

  logic [CNT_W-1:0] h_count_s;
  logic [CNT_W-1:0] v_count_s;
  logic             h_wrap_s;
  logic             v_wrap_unused_s;
  logic             h_sync_raw_s;
  logic             v_sync_raw_s;
  logic             h_active_raw_s;
  logic             v_active_raw_s;
  logic             video_on_s;

  logic [3:0]       red_next_s;
  logic [3:0]       green_next_s;
  logic [3:0]       blue_next_s;
  logic             hsync_r;
  logic             vsync_r;
  logic [3:0]       red_r;
  logic [3:0]       green_r;
  logic [3:0]       blue_r;

  // Divider next state: mod-CLK_DIV count.
  always_comb begin
    div_next_s = div_r;
    if (div_r == DIV_LAST) begin
      div_next_s = DIV_W'(0);
    end else begin
      div_next_s = div_r + DIV_W'(1);
    end
  end

  // The pixel tick is the edge that lifts pixel_clock, i.e. entering the high half.
  assign tick_s = (div_next_s == DIV_HALF);

  // Divider and pixel clock registers; pixel_clock is low for the first half-period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_r         <= DIV_W'(0);
      pixel_clock_r <= 1'b0;
    end else begin
      div_r         <= div_next_s;
      pixel_clock_r <= (div_next_s >= DIV_HALF);
    end
  end

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP)
  ) u_h_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (tick_s),
    .count      (h_count_s),
    .wrap       (h_wrap_s),
    .sync_raw   (h_sync_raw_s),
    .active_raw (h_active_raw_s)
  );

  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP)
  ) u_v_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (tick_s & h_wrap_s),
    .count      (v_count_s),
    .wrap       (v_wrap_unused_s),
    .sync_raw   (v_sync_raw_s),
    .active_raw (v_active_raw_s)
  );

  assign video_on_s = h_active_raw_s & v_active_raw_s;

  // Blank colour outside the visible window.
  always_comb begin
    red_next_s   = 4'h0;
    green_next_s = 4'h0;
    blue_next_s  = 4'h0;
    if (video_on_s) begin
      red_next_s   = red_in;
      green_next_s = green_in;
      blue_next_s  = blue_in;
    end else begin
      red_next_s   = 4'h0;
      green_next_s = 4'h0;
      blue_next_s  = 4'h0;
    end
  end

  // Output registers load on the pixel tick from pre-tick counter decodes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_r <= SYNC_OFF;
      vsync_r <= SYNC_OFF;
      red_r   <= 4'h0;
      green_r <= 4'h0;
      blue_r  <= 4'h0;
    end else if (tick_s) begin
      hsync_r <= sync_level(h_sync_raw_s, SYNC_POL);
      vsync_r <= sync_level(v_sync_raw_s, SYNC_POL);
      red_r   <= red_next_s;
      green_r <= green_next_s;
      blue_r  <= blue_next_s;
    end
  end

  assign pixel_clock    = pixel_clock_r;
  assign pixel_count    = h_count_s;
  assign line_count     = v_count_s;
  assign frame_start    = (h_count_s == CNT_W'(0)) && (v_count_s == CNT_W'(0));
  assign h_active_start = CNT_W'(H_SYNC + H_BP);
  assign h_active       = CNT_W'(H_ACTIVE);
  assign v_active_start = CNT_W'(V_SYNC + V_BP);
  assign v_active       = CNT_W'(V_ACTIVE);
  assign hsync          = hsync_r;
  assign vsync          = vsync_r;
  assign red_out        = red_r;
  assign green_out      = green_r;
  assign blue_out       = blue_r;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: default-timing instance for reset/divider/hsync, and a
// shrunk negative-polarity instance for vertical wrap, blanking and mid-frame reset.
module tb_vga_sync_generator;

  localparam int BH_TOT = 13;
  localparam int BV_TOT = 9;

  int checks   = 0;
  int failures = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default 800x600 timing
  logic        reset_a_n;
  logic [3:0]  red_a_in, green_a_in, blue_a_in;
  logic        pclk_a, fs_a, hs_a, vs_a;
  logic [10:0] pc_a, lc_a, has_a, ha_a, vas_a, va_a;
  logic [3:0]  red_a, green_a, blue_a;

  vga_sync_generator u_dut_a (
    .clock(clock), .reset_n(reset_a_n),
    .red_in(red_a_in), .green_in(green_a_in), .blue_in(blue_a_in),
    .pixel_clock(pclk_a), .pixel_count(pc_a), .line_count(lc_a),
    .h_active_start(has_a), .h_active(ha_a), .v_active_start(vas_a), .v_active(va_a),
    .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a),
    .red_out(red_a), .green_out(green_a), .blue_out(blue_a)
  );

  // Instance B: tiny timing, CLK_DIV=4, negative sync polarity
  logic        reset_b_n;
  logic [3:0]  red_b_in, green_b_in, blue_b_in;
  logic        pclk_b, fs_b, hs_b, vs_b;
  logic [10:0] pc_b, lc_b, has_b, ha_b, vas_b, va_b;
  logic [3:0]  red_b, green_b, blue_b;

  vga_sync_generator #(
    .CLK_DIV(4), .H_SYNC(3), .H_BP(2), .H_ACTIVE(6), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(2), .SYNC_POL(0)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_b_n),
    .red_in(red_b_in), .green_in(green_b_in), .blue_in(blue_b_in),
    .pixel_clock(pclk_b), .pixel_count(pc_b), .line_count(lc_b),
    .h_active_start(has_b), .h_active(ha_b), .v_active_start(vas_b), .v_active(va_b),
    .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b),
    .red_out(red_b), .green_out(green_b), .blue_out(blue_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] col(input int k);
    return 4'((k % 15) + 1);
  endfunction

  task automatic drive_b(input int k);
    red_b_in   = col(k);
    green_b_in = ~col(k);
    blue_b_in  = col(k) ^ 4'hA;
  endtask

  // Runs instance B for n pixel ticks after a release, checking against the model.
  task automatic run_b(input int n);
    int h, v, bad;
    logic [3:0] r_exp, g_exp, b_exp;
    logic hs_exp, vs_exp, fs_exp;
    bad = 0;
    drive_b(1);
    for (int k = 1; k <= n; k++) begin
      if (k == 1) begin
        repeat (2) @(negedge clock);
      end else begin
        repeat (2) @(negedge clock);
        if (pclk_b !== 1'b0) bad++;
        repeat (2) @(negedge clock);
      end
      h = (k - 1) % BH_TOT;
      v = ((k - 1) / BH_TOT) % BV_TOT;
      if (h >= 5 && h < 11 && v >= 3 && v < 7) begin
        r_exp = col(k); g_exp = ~col(k); b_exp = col(k) ^ 4'hA;
      end else begin
        r_exp = 4'h0; g_exp = 4'h0; b_exp = 4'h0;
      end
      hs_exp = (h < 3) ? 1'b0 : 1'b1;
      vs_exp = (v < 2) ? 1'b0 : 1'b1;
      fs_exp = ((k % BH_TOT) == 0) && (((k / BH_TOT) % BV_TOT) == 0);
      if (pc_b !== 11'(k % BH_TOT)) bad++;
      if (lc_b !== 11'((k / BH_TOT) % BV_TOT)) bad++;
      if (pclk_b !== 1'b1) bad++;
      if (hs_b !== hs_exp || vs_b !== vs_exp || fs_b !== fs_exp) bad++;
      if (red_b !== r_exp || green_b !== g_exp || blue_b !== b_exp) bad++;
      if (v == 4 && h == 4)  chk("b_blank_before_start", 32'(red_b), 32'(4'h0));
      if (v == 4 && h == 5)  chk("b_first_visible", 32'(red_b), 32'(col(k)));
      if (v == 4 && h == 11) chk("b_blank_after_end", 32'(red_b), 32'(4'h0));
      if (v == 2 && h == 7)  chk("b_line_before_active", 32'(red_b), 32'(4'h0));
      if (v == 7 && h == 7)  chk("b_line_after_active", 32'(red_b), 32'(4'h0));
      if (k == BH_TOT * BV_TOT) begin
        chk("b_frame_wrap_pc", 32'(pc_b), 32'd0);
        chk("b_frame_wrap_lc", 32'(lc_b), 32'd0);
        chk("b_frame_start", 32'(fs_b), 32'd1);
      end
      drive_b(k + 1);
    end
    chk("b_model", 32'(bad), 32'd0);
  endtask

  initial begin
    int a_bad, hs_high;
    logic hs_exp;
    a_bad = 0;
    hs_high = 0;
    reset_a_n = 1'b0;
    reset_b_n = 1'b0;
    red_a_in = 4'hF; green_a_in = 4'h5; blue_a_in = 4'hA;
    drive_b(1);
    repeat (3) @(negedge clock);

    // Reset state and constants
    chk("a_rst_pc", 32'(pc_a), 32'd0);
    chk("a_rst_lc", 32'(lc_a), 32'd0);
    chk("a_rst_pclk", 32'(pclk_a), 32'd0);
    chk("a_rst_hsync", 32'(hs_a), 32'd0);
    chk("a_rst_vsync", 32'(vs_a), 32'd0);
    chk("a_rst_rgb", 32'({red_a, green_a, blue_a}), 32'd0);
    chk("a_rst_frame_start", 32'(fs_a), 32'd1);
    chk("a_h_active_start", 32'(has_a), 32'd184);
    chk("a_h_active", 32'(ha_a), 32'd800);
    chk("a_v_active_start", 32'(vas_a), 32'd29);
    chk("a_v_active", 32'(va_a), 32'd600);
    chk("b_rst_hsync", 32'(hs_b), 32'd1);
    chk("b_rst_vsync", 32'(vs_b), 32'd1);
    chk("b_h_active_start", 32'(has_b), 32'd5);
    chk("b_v_active_start", 32'(vas_b), 32'd3);

    // Instance A: first tick one clock after release
    reset_a_n = 1'b1;
    @(negedge clock);
    chk("a_first_tick_pc", 32'(pc_a), 32'd1);
    chk("a_first_tick_pclk", 32'(pclk_a), 32'd1);
    chk("a_first_tick_hsync", 32'(hs_a), 32'd1);
    chk("a_first_tick_fs", 32'(fs_a), 32'd0);
    hs_high = (hs_a === 1'b1) ? 1 : 0;

    for (int k = 2; k <= 2085; k++) begin
      @(negedge clock);
      if (pclk_a !== 1'b0) a_bad++;
      @(negedge clock);
      hs_exp = (((k - 1) % 1040) < 120) ? 1'b1 : 1'b0;
      if (pclk_a !== 1'b1) a_bad++;
      if (pc_a !== 11'(k % 1040) || lc_a !== 11'(k / 1040)) a_bad++;
      if (hs_a !== hs_exp || vs_a !== 1'b1) a_bad++;
      if ({red_a, green_a, blue_a} !== 12'h000) a_bad++;
      if (k <= 1040 && hs_a === 1'b1) hs_high++;
      if (k == 120)  chk("a_hsync_last_high", 32'(hs_a), 32'd1);
      if (k == 121)  chk("a_hsync_first_low", 32'(hs_a), 32'd0);
      if (k == 1039) chk("a_pc_max", 32'(pc_a), 32'd1039);
      if (k == 1040) begin
        chk("a_pc_wrap", 32'(pc_a), 32'd0);
        chk("a_lc_step", 32'(lc_a), 32'd1);
        chk("a_hsync_line_end", 32'(hs_a), 32'd0);
      end
      if (k == 1041) chk("a_hsync_restart", 32'(hs_a), 32'd1);
    end
    chk("a_hsync_width", 32'(hs_high), 32'd120);
    chk("a_model", 32'(a_bad), 32'd0);
    reset_a_n = 1'b0;

    // Instance B: run a full frame plus into the next, stopping at (6,4)
    reset_b_n = 1'b1;
    run_b(BH_TOT * BV_TOT + 58);
    chk("b_mid_pc", 32'(pc_b), 32'd6);
    chk("b_mid_lc", 32'(lc_b), 32'd4);

    // Asynchronous mid-frame reset takes effect without a clock edge
    #2;
    reset_b_n = 1'b0;
    #1;
    chk("b_mid_rst_pc", 32'(pc_b), 32'd0);
    chk("b_mid_rst_lc", 32'(lc_b), 32'd0);
    chk("b_mid_rst_pclk", 32'(pclk_b), 32'd0);
    chk("b_mid_rst_hsync", 32'(hs_b), 32'd1);
    chk("b_mid_rst_vsync", 32'(vs_b), 32'd1);
    chk("b_mid_rst_rgb", 32'({red_b, green_b, blue_b}), 32'd0);
    chk("b_mid_rst_fs", 32'(fs_b), 32'd1);
    repeat (2) @(negedge clock);
    reset_b_n = 1'b1;
    run_b(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
